// File: rtl/jedro_1_lsu_pkg.sv
// jedro_1_lsu_pkg: size encodings, FSM states and byte-mask helpers shared by the LSU files.
// The split states exist only when JEDRO_1_LSU_SPLIT_EN is defined.
package jedro_1_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'd0,
        LSU_SIZE_H = 2'd1,
        LSU_SIZE_W = 2'd2,
        LSU_SIZE_D = 2'd3
    } lsu_size_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3
`ifdef JEDRO_1_LSU_SPLIT_EN
        ,
        S_REQ2  = 3'd4,
        S_WAIT2 = 3'd5
`endif
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        return 8'((16'd1 << size_bytes(size)) - 16'd1);
    endfunction

endpackage

// File: rtl/jedro_1_lsu_if.sv
// jedro_1_lsu_if: req/gnt/rvalid data bus between the LSU (master) and memory (slave).
interface jedro_1_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;
    logic                    err;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, err, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/jedro_1_lsu_align.sv
// jedro_1_lsu_align: byte-enable generation, store-data lane shifting and load extraction/extension.
// With SPLIT=1 the enables and lanes span two bus words (lower word first).
module jedro_1_lsu_align
    import jedro_1_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SPLIT = 0,
    localparam int NB = DATA_WIDTH / 8,
    localparam int OW = $clog2(NB),
    localparam int BW = NB * (SPLIT + 1),
    localparam int RW = DATA_WIDTH * (SPLIT + 1)
) (
    input  logic [1:0]            size,
    input  logic                  sgn,
    input  logic [OW-1:0]         offset,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [RW-1:0]         rdata,
    output logic [BW-1:0]         be,
    output logic [RW-1:0]         wdata_sh,
    output logic [DATA_WIDTH-1:0] rdata_ext
);
    logic [DATA_WIDTH-1:0] ld;
    logic [DATA_WIDTH-1:0] fmask;
    logic                  sbit;

    assign be       = BW'(size_mask(size)) << offset;
    assign wdata_sh = RW'(wdata) << {offset, 3'b000};
    assign ld       = DATA_WIDTH'(rdata >> {offset, 3'b000});

    // fmask covers the accessed field; its top bit selects the sign source
    always_comb begin
        fmask     = ((8 << size) >= DATA_WIDTH) ? '1 : (DATA_WIDTH'(1) << (8 << size)) - DATA_WIDTH'(1);
        sbit      = sgn & |(ld & fmask & ~(fmask >> 1));
        rdata_ext = sbit ? (ld | ~fmask) : (ld & fmask);
    end
endmodule

// File: rtl/jedro_1_lsu.sv
// jedro_1_lsu: load/store unit bridging single core requests onto a req/gnt/rvalid data bus.
// Define JEDRO_1_LSU_SPLIT_EN to execute word-boundary-crossing accesses as two bus transactions.
module jedro_1_lsu
    import jedro_1_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ctrl_valid_i,
    output logic                  ctrl_ready_o,
    input  logic                  ctrl_we_i,
    input  logic [1:0]            ctrl_size_i,
    input  logic                  ctrl_signed_i,
    input  logic [ADDR_WIDTH-1:0] ctrl_addr_i,
    input  logic [DATA_WIDTH-1:0] ctrl_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_misaligned_o,
    jedro_1_lsu_if.master         data
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);
`ifdef JEDRO_1_LSU_SPLIT_EN
    localparam int SPLIT = 1;
`else
    localparam int SPLIT = 0;
`endif
    localparam int BW = NB * (SPLIT + 1);
    localparam int RW = DATA_WIDTH * (SPLIT + 1);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [OW-1:0]         off_q;
    logic [1:0]            size_q;
    logic                  we_q, sgn_q, err_q, mis_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [RW-1:0]         rdata_q;
    logic [BW-1:0]         be_w;
    logic [RW-1:0]         wdata_w;
    logic [DATA_WIDTH-1:0] ext_w;
    logic [OW-1:0]         off_in;
    logic                  illegal, skip, in_req;

    assign off_in  = ctrl_addr_i[OW-1:0];
    assign illegal = (DATA_WIDTH == 32) && (ctrl_size_i == LSU_SIZE_D);

`ifdef JEDRO_1_LSU_SPLIT_EN
    logic cross_q, crosses, hi;
    assign crosses = (int'(off_in) + int'(size_bytes(ctrl_size_i))) > NB;
    assign skip    = illegal;
    assign mis_q   = 1'b0;
`else
    logic misaligned;
    assign misaligned = |(off_in & OW'(size_bytes(ctrl_size_i) - 4'd1));
    assign skip       = illegal | misaligned;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef JEDRO_1_LSU_SPLIT_EN
            cross_q <= 1'b0;
`else
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && ctrl_valid_i) begin
                addr_q  <= {ctrl_addr_i[ADDR_WIDTH-1:OW], OW'(0)};
                off_q   <= off_in;
                size_q  <= ctrl_size_i;
                we_q    <= ctrl_we_i;
                sgn_q   <= ctrl_signed_i;
                wdata_q <= ctrl_wdata_i;
                err_q   <= illegal;
`ifdef JEDRO_1_LSU_SPLIT_EN
                cross_q <= crosses;
`else
                mis_q   <= misaligned;
`endif
            end
            if (state_q == S_WAIT && data.rvalid) begin
                rdata_q[DATA_WIDTH-1:0] <= data.rdata;
                err_q                   <= data.err;
            end
`ifdef JEDRO_1_LSU_SPLIT_EN
            if (state_q == S_WAIT2 && data.rvalid) begin
                rdata_q[RW-1:DATA_WIDTH] <= data.rdata;
                err_q                    <= data.err;
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = ctrl_valid_i ? (skip ? S_RESP : S_REQ) : S_IDLE;
            S_REQ:   state_d = data.gnt ? S_WAIT : S_REQ;
`ifdef JEDRO_1_LSU_SPLIT_EN
            // an error on the lower word abandons the upper one
            S_WAIT:  state_d = data.rvalid ? ((cross_q && !data.err) ? S_REQ2 : S_RESP) : S_WAIT;
            S_REQ2:  state_d = data.gnt ? S_WAIT2 : S_REQ2;
            S_WAIT2: state_d = data.rvalid ? S_RESP : S_WAIT2;
`else
            S_WAIT:  state_d = data.rvalid ? S_RESP : S_WAIT;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    jedro_1_lsu_align #(
        .DATA_WIDTH(DATA_WIDTH),
        .SPLIT     (SPLIT)
    ) u_align (
        .size     (size_q),
        .sgn      (sgn_q),
        .offset   (off_q),
        .wdata    (wdata_q),
        .rdata    (rdata_q),
        .be       (be_w),
        .wdata_sh (wdata_w),
        .rdata_ext(ext_w)
    );

`ifdef JEDRO_1_LSU_SPLIT_EN
    assign hi         = state_q == S_REQ2;
    assign in_req     = (state_q == S_REQ) || hi;
    assign data.addr  = in_req ? addr_q + (hi ? ADDR_WIDTH'(NB) : '0) : '0;
    assign data.be    = hi ? be_w[BW-1:NB] : in_req ? be_w[NB-1:0] : '0;
    assign data.wdata = hi ? wdata_w[RW-1:DATA_WIDTH] : in_req ? wdata_w[DATA_WIDTH-1:0] : '0;
`else
    assign in_req     = state_q == S_REQ;
    assign data.addr  = in_req ? addr_q : '0;
    assign data.be    = in_req ? be_w : '0;
    assign data.wdata = in_req ? wdata_w : '0;
`endif
    assign data.req = in_req;
    assign data.we  = in_req & we_q;

    assign ctrl_ready_o     = state_q == S_IDLE;
    assign rsp_valid_o      = state_q == S_RESP;
    assign rsp_err_o        = rsp_valid_o & err_q;
    assign rsp_misaligned_o = rsp_valid_o & mis_q;
    assign rsp_rdata_o      = (rsp_valid_o && !we_q && !err_q && !mis_q) ? ext_w : '0;
endmodule

// File: tb/tb_jedro_1_lsu.sv
// tb_jedro_1_lsu: scoreboard bench for jedro_1_lsu with a programmable-latency bus slave.
// Directed cases cover alignment, extension, errors, reset; a short random loop covers aligned traffic.
module tb_jedro_1_lsu;
    logic        clk = 1'b1;
    logic        rst = 1'b1;
    logic        ctrl_valid_i = 1'b0, ctrl_we_i = 1'b0, ctrl_signed_i = 1'b0;
    logic [1:0]  ctrl_size_i = 2'd0;
    logic [31:0] ctrl_addr_i = '0, ctrl_wdata_i = '0;
    logic        ctrl_ready_o, rsp_valid_o, rsp_err_o, rsp_misaligned_o;
    logic [31:0] rsp_rdata_o;

    int          n_checks = 0, n_errors = 0, n_rsp = 0, held = 0, rv_cnt = 0;
    logic [31:0] rv_data = '0;
    logic        rv_err = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          gdly;
        int          rvdly;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
    } rsp_t;

    beat_t beat_q[$];
    rsp_t  exp_q[$];

    jedro_1_lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) data_if ();

    jedro_1_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ctrl_valid_i    (ctrl_valid_i),
        .ctrl_ready_o    (ctrl_ready_o),
        .ctrl_we_i       (ctrl_we_i),
        .ctrl_size_i     (ctrl_size_i),
        .ctrl_signed_i   (ctrl_signed_i),
        .ctrl_addr_i     (ctrl_addr_i),
        .ctrl_wdata_i    (ctrl_wdata_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_rdata_o     (rsp_rdata_o),
        .rsp_err_o       (rsp_err_o),
        .rsp_misaligned_o(rsp_misaligned_o),
        .data            (data_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic exp_beat(input logic [31:0] addr, input logic [3:0] be, input logic we,
                            input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                            input int gdly, input int rvdly);
        beat_t b;
        b.addr = addr; b.be = be; b.we = we; b.wdata = wdata;
        b.rdata = rdata; b.err = err; b.gdly = gdly; b.rvdly = rvdly;
        beat_q.push_back(b);
    endtask

    task automatic exp_rsp(input logic [31:0] rdata, input logic err, input logic mis);
        rsp_t r;
        r.rdata = rdata; r.err = err; r.mis = mis;
        exp_q.push_back(r);
    endtask

    function automatic logic [31:0] ld_model(input logic [31:0] r, input int size, input int off, input logic sgn);
        int n;
        logic [31:0] v;
        n = 1 << size;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = r[8*(off+i) +: 8];
        if (sgn && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] be_model(input int size, input int off);
        logic [3:0] b;
        b = '0;
        for (int i = 0; i < (1 << size); i++) b[off+i] = 1'b1;
        return b;
    endfunction

    // bus slave: grants after gdly cycles of req, returns rvalid rvdly cycles after the grant
    always @(negedge clk) begin
        data_if.gnt    = 1'b0;
        data_if.rvalid = 1'b0;
        data_if.err    = 1'b0;
        data_if.rdata  = '0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                data_if.rvalid = 1'b1;
                data_if.rdata  = rv_data;
                data_if.err    = rv_err;
            end
        end
        if (data_if.req === 1'b1) begin
            if (beat_q.size() == 0) check("unexpected_req", data_if.req, 1'b0);
            else begin
                check("bus_addr", data_if.addr, beat_q[0].addr);
                check("bus_be", data_if.be, beat_q[0].be);
                check("bus_we", data_if.we, beat_q[0].we);
                if (beat_q[0].we) check("bus_wdata", data_if.wdata, beat_q[0].wdata);
                if (held == beat_q[0].gdly) begin
                    data_if.gnt = 1'b1;
                    held        = 0;
                    rv_cnt      = beat_q[0].rvdly;
                    rv_data     = beat_q[0].rdata;
                    rv_err      = beat_q[0].err;
                    void'(beat_q.pop_front());
                end else held++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid_o) begin
            rsp_t e;
            n_rsp++;
            if (exp_q.size() == 0) check("unexpected_rsp", rsp_valid_o, 1'b0);
            else begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata_o, e.rdata);
                check("rsp_err", rsp_err_o, e.err);
                check("rsp_mis", rsp_misaligned_o, e.mis);
            end
        end
    end

    task automatic op(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata, input int lat);
        int c;
        check("idle_ready", ctrl_ready_o, 1'b1);
        ctrl_valid_i  = 1'b1;
        ctrl_we_i     = we;
        ctrl_size_i   = size;
        ctrl_signed_i = sgn;
        ctrl_addr_i   = addr;
        ctrl_wdata_i  = wdata;
        @(negedge clk);
        ctrl_valid_i = 1'b0;
        check("busy_ready", ctrl_ready_o, 1'b0);
        c = 1;
        while (!rsp_valid_o && c < 64) begin
            @(negedge clk);
            c++;
        end
        check("rsp_latency", c, lat);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t exceeds limit 500000", $time);
        $fatal(1);
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ctrl_ready_o, 1'b1);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        check("rst_rsp_err", rsp_err_o, 1'b0);
        check("rst_rsp_mis", rsp_misaligned_o, 1'b0);
        check("rst_req", data_if.req, 1'b0);
        check("rst_be", data_if.be, 4'h0);
        check("rst_addr", data_if.addr, 32'h0);

        exp_beat(32'h100, 4'hF, 1'b0, '0, 32'hDEADBEEF, 1'b0, 0, 1);
        exp_rsp(32'hDEADBEEF, 1'b0, 1'b0);
        op(1'b0, 2'd2, 1'b0, 32'h100, '0, 3);

        exp_beat(32'h100, 4'h8, 1'b0, '0, 32'h80FFFFFF, 1'b0, 0, 1);
        exp_rsp(32'hFFFFFF80, 1'b0, 1'b0);
        op(1'b0, 2'd0, 1'b1, 32'h103, '0, 3);
        exp_beat(32'h100, 4'h8, 1'b0, '0, 32'h80FFFFFF, 1'b0, 0, 1);
        exp_rsp(32'h00000080, 1'b0, 1'b0);
        op(1'b0, 2'd0, 1'b0, 32'h103, '0, 3);

        exp_beat(32'h100, 4'hC, 1'b1, 32'h12340000, 32'h55555555, 1'b0, 3, 1);
        exp_rsp(32'h0, 1'b0, 1'b0);
        op(1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234, 6);

`ifdef JEDRO_1_LSU_SPLIT_EN
        exp_beat(32'h100, 4'hE, 1'b0, '0, 32'hAABBCCDD, 1'b0, 0, 1);
        exp_beat(32'h104, 4'h1, 1'b0, '0, 32'h11223344, 1'b0, 0, 1);
        exp_rsp(32'h44AABBCC, 1'b0, 1'b0);
        op(1'b0, 2'd2, 1'b0, 32'h101, '0, 5);
        exp_beat(32'h100, 4'h6, 1'b0, '0, 32'h00ABCD00, 1'b0, 0, 1);
        exp_rsp(32'hFFFFABCD, 1'b0, 1'b0);
        op(1'b0, 2'd1, 1'b1, 32'h101, '0, 3);
        exp_beat(32'h100, 4'h8, 1'b1, 32'hBB000000, '0, 1'b0, 1, 1);
        exp_beat(32'h104, 4'h1, 1'b1, 32'h000000AA, '0, 1'b0, 0, 1);
        exp_rsp(32'h0, 1'b0, 1'b0);
        op(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000AABB, 6);
        exp_beat(32'h100, 4'hE, 1'b0, '0, 32'hAABBCCDD, 1'b1, 0, 1);
        exp_rsp(32'h0, 1'b1, 1'b0);
        op(1'b0, 2'd2, 1'b0, 32'h101, '0, 3);
`else
        exp_rsp(32'h0, 1'b0, 1'b1);
        op(1'b0, 2'd2, 1'b0, 32'h101, '0, 1);
        exp_rsp(32'h0, 1'b0, 1'b1);
        op(1'b0, 2'd1, 1'b1, 32'h101, '0, 1);
        exp_rsp(32'h0, 1'b0, 1'b1);
        op(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000AABB, 1);
`endif

        exp_beat(32'h104, 4'hF, 1'b0, '0, 32'h12345678, 1'b1, 0, 1);
        exp_rsp(32'h0, 1'b1, 1'b0);
        op(1'b0, 2'd2, 1'b0, 32'h104, '0, 3);

        exp_rsp(32'h0, 1'b1, 1'b0);
        op(1'b0, 2'd3, 1'b0, 32'h100, '0, 1);

        exp_beat(32'h300, 4'hF, 1'b0, '0, 32'hCAFEF00D, 1'b0, 0, 4);
        base          = n_rsp;
        ctrl_valid_i  = 1'b1;
        ctrl_we_i     = 1'b0;
        ctrl_size_i   = 2'd2;
        ctrl_signed_i = 1'b0;
        ctrl_addr_i   = 32'h300;
        @(negedge clk);
        ctrl_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", ctrl_ready_o, 1'b1);
        repeat (5) @(negedge clk);
        check("late_rvalid_rsp", n_rsp, base);
        check("late_rvalid_ready", ctrl_ready_o, 1'b1);
        check("late_rvalid_req", data_if.req, 1'b0);

        exp_beat(32'h400, 4'hF, 1'b0, '0, 32'h0BADF00D, 1'b0, 0, 1);
        exp_rsp(32'h0BADF00D, 1'b0, 1'b0);
        op(1'b0, 2'd2, 1'b0, 32'h400, '0, 3);

        for (int i = 0; i < 16; i++) begin
            logic [1:0]  sz;
            logic        sg, w;
            logic [31:0] rd, wd, a;
            int          off, g, r;
            sz  = 2'($urandom_range(0, 2));
            sg  = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            rd  = $urandom;
            wd  = $urandom;
            off = int'($urandom_range(0, 3)) & ~((1 << sz) - 1);
            g   = int'($urandom_range(0, 2));
            r   = int'($urandom_range(1, 2));
            a   = 32'h200 + 32'(i * 4 + off);
            exp_beat(a & ~32'h3, be_model(int'(sz), off), w, wd << (8 * off), rd, 1'b0, g, r);
            exp_rsp(w ? 32'h0 : ld_model(rd, int'(sz), off, sg), 1'b0, 1'b0);
            op(w, sz, sg, a, wd, 2 + g + r);
        end

        check("beats_left", beat_q.size(), 0);
        check("rsps_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
